// File: rtl/dma_w_burst_buf.sv
// ---------------------------------------------------------------------------
// dma_w_burst_buf
//
// Write-path front end for the DMA AXI write engine. Words arriving from the
// native DMA data path are buffered in an internal FIFO. A programmed transfer
// of N beats is cut into AXI-legal bursts. Each burst is offered to the
// downstream write engine as valid/addr/dma_len, together with a show-ahead
// FIFO head (wdata/wstrb) that the engine pops with its ready pulses.
//
// Optional feature macro: DMA_W_4K_SPLIT_EN
//   defined   : bursts are also limited so that none crosses a 4 KB boundary
//   undefined : bursts are limited only by the remaining beats and MAX_BURST
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_start       start pulse (ignored while busy)
//   cfg_addr        transfer start byte address (forced to word alignment)
//   cfg_nbeats      total beats of the transfer (0 = empty transfer)
//   busy, done      transfer in progress / one-cycle completion pulse
//   s_valid/s_ready/s_data/s_strb   upstream word stream into the FIFO
//   valid, addr, dma_len            burst request to the write engine
//   wdata, wstrb                    FIFO head word and strobes (show-ahead)
//   ready           pop pulse from the write engine (one beat per cycle high)
//   dma_ready       write engine idle (burst response finished)
// ---------------------------------------------------------------------------

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module dma_w_burst_buf #(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int BUF_AW         = 8,
  parameter int MAX_BURST      = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [`AXI_ADDR_W-1:0]        cfg_addr,
  input  logic [15:0]                   cfg_nbeats,
  output logic                          busy,
  output logic                          done,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DMA_DATA_WIDTH-1:0]     s_data,
  input  logic [DMA_DATA_WIDTH/8-1:0]   s_strb,
  output logic                          valid,
  output logic [`AXI_ADDR_W-1:0]        addr,
  output logic [`AXI_LEN_W-1:0]         dma_len,
  output logic [DMA_DATA_WIDTH-1:0]     wdata,
  output logic [DMA_DATA_WIDTH/8-1:0]   wstrb,
  input  logic                          ready,
  input  logic                          dma_ready
);

  localparam int B     = DMA_DATA_WIDTH / 8;
  localparam int BSH   = $clog2(B);
  localparam int DEPTH = 1 << BUF_AW;
  localparam int AW    = `AXI_ADDR_W;
  localparam int LW    = `AXI_LEN_W;
  localparam int EW    = DMA_DATA_WIDTH + B;   // FIFO entry: {strb, data}

  localparam logic [AW-1:0]     ALIGN_MASK = ~(AW'((1 << BSH) - 1));
  localparam logic [BUF_AW-1:0] PTR_ONE    = BUF_AW'(1);
  localparam logic [BUF_AW:0]   LVL_FULL   = (BUF_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FILL,
    S_BURST,
    S_DRAIN
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [15:0]       r_nbeats;
  logic [15:0]       r_wr_cnt;
  logic [16:0]       r_rem;
  logic [AW-1:0]     r_cur_addr;
  logic [8:0]        r_blen;
  logic [8:0]        r_pop_cnt;
  logic [LW-1:0]     r_dma_len;
  logic [BUF_AW:0]   r_level;
  logic [BUF_AW-1:0] r_wr_ptr;
  logic [BUF_AW-1:0] r_rd_ptr;
  logic [EW-1:0]     r_head;
  logic [EW-1:0]     r_mem [DEPTH];

  // ---------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------
  state_t            w_state_next;
  logic              w_s_ready;
  logic              w_push;
  logic              w_pop;
  logic [BUF_AW-1:0] w_rd_addr_next;
  logic [8:0]        w_blen_calc;
  logic              w_load;
  logic              w_zero_done;
  logic              w_calc;
  logic              w_burst_end;
  logic              w_finish;
  logic              w_fill_ok;

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
  // Upstream acceptance does not depend on FSM state, so the next burst can
  // fill while the current one is still being popped.
  assign w_s_ready = r_busy && (r_wr_cnt < r_nbeats) && (r_level < LVL_FULL);
  assign w_push    = s_valid && w_s_ready;
  // A pop request against an empty FIFO is simply dropped.
  assign w_pop     = ready && (r_level != '0);

  assign w_fill_ok = (32'(r_level) >= 32'(r_blen));

  // Head-register read address: the entry that will be at the head after
  // this cycle's pop (if any).
  assign w_rd_addr_next = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  // ---------------------------------------------------------------------
  // Burst length: min(rem, MAX_BURST[, beats left in the 4 KB page])
  // ---------------------------------------------------------------------
`ifdef DMA_W_4K_SPLIT_EN
  logic [12:0] w_4k_beats;
  assign w_4k_beats = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> BSH;
`endif

  always_comb begin
    w_blen_calc = (r_rem > 17'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(r_rem);
`ifdef DMA_W_4K_SPLIT_EN
    if (32'(w_4k_beats) < 32'(w_blen_calc)) begin
      w_blen_calc = 9'(w_4k_beats);
    end
`endif
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_zero_done  = 1'b0;
    w_calc       = 1'b0;
    w_burst_end  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_nbeats == 16'd0) begin
            // Empty transfer: only a done pulse, never becomes busy.
            w_zero_done = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_calc       = 1'b1;
        w_state_next = S_FILL;
      end
      S_FILL: begin
        // Whole burst must be buffered before it is offered, so the engine
        // never sees the FIFO run dry mid-burst.
        if (w_fill_ok) begin
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (w_pop && ((r_pop_cnt + 9'd1) == r_blen)) begin
          w_burst_end  = 1'b1;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dma_ready) begin
          if (r_rem != 17'd0) begin
            w_state_next = S_CALC;
          end else begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state register and transfer bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_nbeats   <= '0;
      r_wr_cnt   <= '0;
      r_rem      <= '0;
      r_cur_addr <= '0;
      r_blen     <= '0;
      r_pop_cnt  <= '0;
      r_dma_len  <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_zero_done || w_finish;
      r_valid <= (w_state_next == S_BURST);

      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end

      if (w_load) begin
        r_nbeats   <= cfg_nbeats;
        r_rem      <= {1'b0, cfg_nbeats};
        r_cur_addr <= cfg_addr & ALIGN_MASK;
      end else if (w_burst_end) begin
        r_rem      <= r_rem - 17'(r_blen);
        r_cur_addr <= r_cur_addr + (AW'(r_blen) << BSH);
      end

      if (w_load) begin
        r_wr_cnt <= '0;
      end else if (w_push) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end

      if (w_calc) begin
        r_blen <= w_blen_calc;
      end

      // The counter restarts while the burst is filling, so stray pops
      // outside a burst never shorten the next one.
      if (r_state == S_FILL) begin
        r_pop_cnt <= '0;
        r_dma_len <= LW'(r_blen - 9'd1);
      end else if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + 9'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers, level and show-ahead head register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // The word being written this cycle lands exactly on the next head
      // slot only when the FIFO is (or is about to become) empty; forward it
      // so it shows up one cycle after the push.
      if (w_push && (r_wr_ptr == w_rd_addr_next)) begin
        r_head <= {s_strb, s_data};
      end else begin
        r_head <= r_mem[w_rd_addr_next];
      end
    end
  end

  // Storage array without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_strb, s_data};
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy    = r_busy;
  assign done    = r_done;
  assign s_ready = w_s_ready;
  assign valid   = r_valid;
  assign addr    = r_cur_addr;
  assign dma_len = r_dma_len;
  assign wdata   = r_head[DMA_DATA_WIDTH-1:0];
  assign wstrb   = r_head[EW-1:DMA_DATA_WIDTH];

endmodule

// File: tb/tb_dma_w_burst_buf.sv
// ---------------------------------------------------------------------------
// tb_dma_w_burst_buf
//
// Directed bench for dma_w_burst_buf (default parameters: 32-bit data,
// 256-entry FIFO, MAX_BURST 256). Inputs are driven and outputs sampled on
// the falling clock edge. A simple write-engine model pops whenever valid is
// high and holds dma_ready low for a few cycles after each burst.
// ---------------------------------------------------------------------------
module tb_dma_w_burst_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_nbeats = '0;
  logic        busy;
  logic        done;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [3:0]  s_strb = '0;
  logic        valid;
  logic [31:0] addr;
  logic [7:0]  dma_len;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready = 1'b0;
  logic        dma_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  logic [35:0] popped[$];
  int          done_cnt;
  bit          got_done;

  always #5 clk = ~clk;

  dma_w_burst_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_addr   (cfg_addr),
    .cfg_nbeats (cfg_nbeats),
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_strb     (s_strb),
    .valid      (valid),
    .addr       (addr),
    .dma_len    (dma_len),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .ready      (ready),
    .dma_ready  (dma_ready)
  );

  // Word i of a transfer: {strb, data}.
  function automatic logic [35:0] pat(input int i);
    return {4'(i + 1), 32'hC0DE_0000 + 32'(i)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cfg_start = 1'b0; s_valid = 1'b0; ready = 1'b0; dma_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic start_xfer(input logic [31:0] a, input int n);
    cfg_addr = a; cfg_nbeats = 16'(n); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Feeds n words and plays the write engine until done or the cycle budget.
  task automatic run_xfer(input int n, input int max_cyc);
    int  pushed = 0;
    int  resp = 0;
    bit  pv = 1'b0;
    obs_addr.delete(); obs_len.delete(); popped.delete();
    done_cnt = 0; got_done = 1'b0;
    for (int c = 0; c < max_cyc && !got_done; c++) begin
      if (done) begin done_cnt++; got_done = 1'b1; end
      if (valid && !pv) begin
        obs_addr.push_back(addr); obs_len.push_back(dma_len);
        $display("[%0t] burst addr=0x%08h len=%0d", $time, addr, dma_len);
      end
      if (pv && !valid) resp = 3;
      pv = valid;
      ready = valid;
      if (valid) popped.push_back({wstrb, wdata});
      dma_ready = !valid && (resp == 0);
      if (resp > 0) resp--;
      if (pushed < n) begin
        s_valid = 1'b1; {s_strb, s_data} = pat(pushed);
        if (s_ready) pushed++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; ready = 1'b0; dma_ready = 1'b1;
    repeat (3) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp += 8;
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
    if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %0h want 0", done); end
    if (s_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_s_ready: got %0h want 0", s_ready); end
    if (valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %0h want 0", valid); end
    if (addr !== 32'h0)    begin n_bad++; $display("FAIL reset_addr: got %0h want 0", addr); end
    if (dma_len !== 8'h0)  begin n_bad++; $display("FAIL reset_dma_len: got %0h want 0", dma_len); end
    if (wdata !== 32'h0)   begin n_bad++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
    if (wstrb !== 4'h0)    begin n_bad++; $display("FAIL reset_wstrb: got %0h want 0", wstrb); end
    $display("[%0t] reset values checked", $time);
  endtask

  task automatic test_single_burst();
    do_reset();
    start_xfer(32'h1000, 4);
    n_cmp += 2;
    if (busy !== 1'b1)    begin n_bad++; $display("FAIL single_busy_c1: got %0h want 1", busy); end
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL single_s_ready_c1: got %0h want 1", s_ready); end
    run_xfer(4, 200);
    n_cmp++;
    if (!got_done) begin n_bad++; $display("FAIL single_timeout: got no done want done"); end
    n_cmp++;
    if (obs_addr.size() !== 1) begin n_bad++; $display("FAIL single_nbursts: got %0d want 1", obs_addr.size()); end
    else begin
      n_cmp += 2;
      if (obs_addr[0] !== 32'h1000) begin n_bad++; $display("FAIL single_addr: got %0h want 1000", obs_addr[0]); end
      if (obs_len[0] !== 8'd3)      begin n_bad++; $display("FAIL single_len: got %0d want 3", obs_len[0]); end
    end
    n_cmp++;
    if (popped.size() !== 4) begin n_bad++; $display("FAIL single_npops: got %0d want 4", popped.size()); end
    for (int i = 0; i < popped.size() && i < 4; i++) begin
      n_cmp++;
      if (popped[i] !== pat(i)) begin n_bad++; $display("FAIL single_data[%0d]: got %0h want %0h", i, popped[i], pat(i)); end
    end
    n_cmp += 2;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    if (busy !== 1'b0)  begin n_bad++; $display("FAIL single_busy_end: got %0h want 0", busy); end
  endtask

  task automatic test_long_transfer();
    logic [31:0] ea [3] = '{32'h0, 32'h400, 32'h800};
    logic [7:0]  el [3] = '{8'd255, 8'd255, 8'd87};
    do_reset();
    start_xfer(32'h0, 600);
    run_xfer(600, 3000);
    n_cmp++;
    if (!got_done) begin n_bad++; $display("FAIL long_timeout: got no done want done"); end
    n_cmp++;
    if (obs_addr.size() !== 3) begin n_bad++; $display("FAIL long_nbursts: got %0d want 3", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
      n_cmp += 2;
      if (obs_addr[i] !== ea[i]) begin n_bad++; $display("FAIL long_addr[%0d]: got %0h want %0h", i, obs_addr[i], ea[i]); end
      if (obs_len[i] !== el[i])  begin n_bad++; $display("FAIL long_len[%0d]: got %0d want %0d", i, obs_len[i], el[i]); end
    end
    n_cmp++;
    if (popped.size() !== 600) begin n_bad++; $display("FAIL long_npops: got %0d want 600", popped.size()); end
    for (int i = 0; i < popped.size() && i < 600; i++) begin
      n_cmp++;
      if (popped[i] !== pat(i)) begin n_bad++; $display("FAIL long_data[%0d]: got %0h want %0h", i, popped[i], pat(i)); end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL long_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_4k_split();
`ifdef DMA_W_4K_SPLIT_EN
    int nb = 2;
    logic [31:0] ea [2] = '{32'h0FF0, 32'h1000};
    logic [7:0]  el [2] = '{8'd3, 8'd11};
`else
    int nb = 1;
    logic [31:0] ea [1] = '{32'h0FF0};
    logic [7:0]  el [1] = '{8'd15};
`endif
    do_reset();
    start_xfer(32'h0FF0, 16);
    run_xfer(16, 400);
    n_cmp++;
    if (!got_done) begin n_bad++; $display("FAIL split_timeout: got no done want done"); end
    n_cmp++;
    if (obs_addr.size() !== nb) begin n_bad++; $display("FAIL split_nbursts: got %0d want %0d", obs_addr.size(), nb); end
    for (int i = 0; i < obs_addr.size() && i < nb; i++) begin
      n_cmp += 2;
      if (obs_addr[i] !== ea[i]) begin n_bad++; $display("FAIL split_addr[%0d]: got %0h want %0h", i, obs_addr[i], ea[i]); end
      if (obs_len[i] !== el[i])  begin n_bad++; $display("FAIL split_len[%0d]: got %0d want %0d", i, obs_len[i], el[i]); end
    end
    n_cmp++;
    if (popped.size() !== 16) begin n_bad++; $display("FAIL split_npops: got %0d want 16", popped.size()); end
    for (int i = 0; i < popped.size() && i < 16; i++) begin
      n_cmp++;
      if (popped[i] !== pat(i)) begin n_bad++; $display("FAIL split_data[%0d]: got %0h want %0h", i, popped[i], pat(i)); end
    end
  endtask

  task automatic test_backpressure_empty();
    int pushed = 0;
    int c = 0;
    // Fill with no pops: FIFO saturates at 256 and s_ready drops.
    do_reset();
    start_xfer(32'h0, 300);
    while (s_ready && c < 400) begin
      s_valid = 1'b1; {s_strb, s_data} = pat(pushed); pushed++;
      @(negedge clk); c++;
    end
    {s_strb, s_data} = pat(pushed);
    repeat (5) @(negedge clk);
    n_cmp += 4;
    if (s_ready !== 1'b0)           begin n_bad++; $display("FAIL bp_s_ready_full: got %0h want 0", s_ready); end
    if (dut.r_level !== 9'd256)     begin n_bad++; $display("FAIL bp_level_full: got %0d want 256", dut.r_level); end
    if (pushed !== 256)             begin n_bad++; $display("FAIL bp_accepted: got %0d want 256", pushed); end
    if (valid !== 1'b1)             begin n_bad++; $display("FAIL bp_valid_full: got %0h want 1", valid); end
    // One pop alone, then pop together with a push.
    s_valid = 1'b0; ready = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (dut.r_level !== 9'd255) begin n_bad++; $display("FAIL bp_level_pop: got %0d want 255", dut.r_level); end
    if (s_ready !== 1'b1)       begin n_bad++; $display("FAIL bp_s_ready_pop: got %0h want 1", s_ready); end
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; ready = 1'b0;
    n_cmp += 2;
    if (dut.r_level !== 9'd255)      begin n_bad++; $display("FAIL bp_level_pushpop: got %0d want 255", dut.r_level); end
    if ({wstrb, wdata} !== pat(2))   begin n_bad++; $display("FAIL bp_head_after_2pops: got %0h want %0h", {wstrb, wdata}, pat(2)); end
    $display("[%0t] backpressure sequence done", $time);

    // ready against an empty FIFO, then first word show-ahead latency.
    do_reset();
    start_xfer(32'h0, 4);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut.r_level !== 9'd0) begin n_bad++; $display("FAIL empty_level: got %0d want 0", dut.r_level); end
    s_valid = 1'b1; {s_strb, s_data} = pat(7);
    @(negedge clk);
    s_valid = 1'b0; ready = 1'b0;
    n_cmp += 2;
    if (dut.r_level !== 9'd1)       begin n_bad++; $display("FAIL empty_push_level: got %0d want 1", dut.r_level); end
    if ({wstrb, wdata} !== pat(7))  begin n_bad++; $display("FAIL empty_show_ahead: got %0h want %0h", {wstrb, wdata}, pat(7)); end
    $display("[%0t] empty-ready sequence done", $time);
  endtask

  task automatic test_edge_config();
    bit saw_valid = 1'b0;
    do_reset();
    start_xfer(32'h0, 0);
    n_cmp += 2;
    if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done_c1: got %0h want 1", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_c1: got %0h want 0", busy); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_c2: got %0h want 0", done); end
    for (int i = 0; i < 6; i++) begin
      if (valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid: got %0h want 0", saw_valid); end

    // Second start while busy must not disturb the running transfer.
    start_xfer(32'h2000, 4);
    n_cmp += 2;
    if (busy !== 1'b1)    begin n_bad++; $display("FAIL ign_busy_c1: got %0h want 1", busy); end
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL ign_s_ready_c1: got %0h want 1", s_ready); end
    cfg_addr = 32'h3000; cfg_nbeats = 16'd8; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_addr = 32'h2000; cfg_nbeats = 16'd4;
    run_xfer(4, 200);
    n_cmp++;
    if (obs_addr.size() !== 1) begin n_bad++; $display("FAIL ign_nbursts: got %0d want 1", obs_addr.size()); end
    else begin
      n_cmp += 2;
      if (obs_addr[0] !== 32'h2000) begin n_bad++; $display("FAIL ign_addr: got %0h want 2000", obs_addr[0]); end
      if (obs_len[0] !== 8'd3)      begin n_bad++; $display("FAIL ign_len: got %0d want 3", obs_len[0]); end
    end
    n_cmp += 2;
    if (popped.size() !== 4) begin n_bad++; $display("FAIL ign_npops: got %0d want 4", popped.size()); end
    if (done_cnt !== 1)      begin n_bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    int pushed = 0;
    int c = 0;
    do_reset();
    start_xfer(32'h40, 8);
    while (!valid && c < 60) begin
      if (pushed < 8) begin
        s_valid = 1'b1; {s_strb, s_data} = pat(pushed);
        if (s_ready) pushed++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk); c++;
    end
    s_valid = 1'b0;
    n_cmp++;
    if (valid !== 1'b1) begin n_bad++; $display("FAIL mid_reach_burst: got %0h want 1", valid); end
    ready = 1'b1;
    repeat (2) @(negedge clk);
    // Assert reset between clock edges; outputs must clear without a clock.
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 8;
    if (busy !== 1'b0)     begin n_bad++; $display("FAIL mid_busy: got %0h want 0", busy); end
    if (done !== 1'b0)     begin n_bad++; $display("FAIL mid_done: got %0h want 0", done); end
    if (s_ready !== 1'b0)  begin n_bad++; $display("FAIL mid_s_ready: got %0h want 0", s_ready); end
    if (valid !== 1'b0)    begin n_bad++; $display("FAIL mid_valid: got %0h want 0", valid); end
    if (addr !== 32'h0)    begin n_bad++; $display("FAIL mid_addr: got %0h want 0", addr); end
    if (dma_len !== 8'h0)  begin n_bad++; $display("FAIL mid_dma_len: got %0h want 0", dma_len); end
    if (wdata !== 32'h0)   begin n_bad++; $display("FAIL mid_wdata: got %0h want 0", wdata); end
    if (wstrb !== 4'h0)    begin n_bad++; $display("FAIL mid_wstrb: got %0h want 0", wstrb); end
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_xfer(32'h1000, 4);
    run_xfer(4, 200);
    n_cmp += 2;
    if (!got_done)             begin n_bad++; $display("FAIL mid_after_timeout: got no done want done"); end
    if (obs_addr.size() !== 1) begin n_bad++; $display("FAIL mid_after_nbursts: got %0d want 1", obs_addr.size()); end
    else begin
      n_cmp += 2;
      if (obs_addr[0] !== 32'h1000) begin n_bad++; $display("FAIL mid_after_addr: got %0h want 1000", obs_addr[0]); end
      if (obs_len[0] !== 8'd3)      begin n_bad++; $display("FAIL mid_after_len: got %0d want 3", obs_len[0]); end
    end
    n_cmp++;
    if (popped.size() !== 4) begin n_bad++; $display("FAIL mid_after_npops: got %0d want 4", popped.size()); end
    for (int i = 0; i < popped.size() && i < 4; i++) begin
      n_cmp++;
      if (popped[i] !== pat(i)) begin n_bad++; $display("FAIL mid_after_data[%0d]: got %0h want %0h", i, popped[i], pat(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_long_transfer();
    test_4k_split();
    test_backpressure_empty();
    test_edge_config();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_w_burst_buf.md
# dma_w_burst_buf

Write-path front end for the DMA AXI write engine.
- Accepts a word stream from the native DMA data path into an internal FIFO.
- Splits a programmed transfer of N beats into AXI-legal bursts.
- Presents each burst to the downstream write engine as `valid`/`addr`/`dma_len` plus a show-ahead data head (`wdata`/`wstrb`), which that engine pops with its `ready` pulses.
- Sits directly upstream of the write engine; its `dma_ready` output is consumed here.

## Interface

Parameters:
- `DMA_DATA_WIDTH`, 32, data width; byte count B = DMA_DATA_WIDTH/8, a power of two.
- `BUF_AW`, 8, FIFO address width; depth 2^BUF_AW. Must be ≥ 8.
- `MAX_BURST`, 256, max beats per burst; ≤ 2^BUF_AW and ≤ 2^`AXI_LEN_W`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_start`  in  1  start pulse; ignored while `busy`.
- `cfg_addr`  in  `AXI_ADDR_W`  start byte address; low log2(B) bits are forced to 0.
- `cfg_nbeats`  in  16  total beats; 0 means an empty transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  upstream word accepted when `s_valid`&`s_ready`.
- `s_data`  in  DMA_DATA_WIDTH  upstream word.
- `s_strb`  in  B  upstream strobes.
- `valid`  out  1  burst request to the write engine.
- `addr`  out  `AXI_ADDR_W`  burst start address.
- `dma_len`  out  `AXI_LEN_W`  beats-1 of the current burst.
- `wdata`  out  DMA_DATA_WIDTH  FIFO head word (show-ahead).
- `wstrb`  out  B  FIFO head strobes.
- `ready`  in  1  pop pulse from the write engine; one beat consumed per cycle high.
- `dma_ready`  in  1  write engine idle (registered in the engine).

## Operation

- Registered state: `wr_cnt` (beats accepted, 16b), `rem` (beats not yet issued, 17b), `cur_addr`, `blen` (9b beats of current burst), `pop_cnt` (9b), FIFO `level` (BUF_AW+1 b).
- States:
  - **IDLE**: on `cfg_start`, load the config, set `busy`, go to CALC. If `cfg_nbeats`==0, pulse `done` next cycle and stay IDLE.
  - **CALC** (1 cycle): `blen` = min(`rem`, MAX_BURST, 4 KB limit when `DMA_W_4K_SPLIT_EN` is defined). Go to FILL.
  - **FILL**: wait until `level` ≥ `blen`, then go to BURST.
  - **BURST**: `valid`=1 and `dma_len`=`blen`-1, both registered. Stay until `pop_cnt` reaches `blen`; then `rem` -= `blen`, `cur_addr` += `blen`*B, go to DRAIN.
  - **DRAIN**: `valid`=0. Wait for `dma_ready`==1 (response finished). Then go to CALC if `rem`≠0; otherwise pulse `done`, clear `busy`, go to IDLE.
- `s_ready` = `busy` & (`wr_cnt` < `cfg_nbeats`) & (`level` < depth). It is independent of FSM state, so filling of the next burst overlaps the current one.
- Pops:
  - A pop happens on any cycle where `ready`=1 and `level`≠0; `pop_cnt` increments.
  - `ready` with an empty FIFO is ignored: no pointer change, `wdata` unchanged.
  - A simultaneous push and pop leaves `level` unchanged.
- `wdata`/`wstrb` always show the FIFO head; the value is undefined content when empty.
- Pointers wrap modulo depth; full/empty are distinguished by `level`.
- An asserted `rst_n` mid-transfer discards FIFO contents and all counters.

## Timing

- Reset values: `busy`=0, `done`=0, `s_ready`=0, `valid`=0, `addr`=0, `dma_len`=0, `wdata`=0, `wstrb`=0.
- `cfg_start` in cycle 0 → `busy`=1 and `s_ready`=1 in cycle 1.
- The cycle in which `level` reaches `blen` in FILL → `valid`=1 in the next cycle.
- A pushed word is visible on `wdata` 1 cycle after the push when the FIFO was empty.
- The last pop of a burst in cycle t → `valid`=0 in t+1.
- `dma_ready`=1 sampled in DRAIN at cycle t → `done`=1 in t+1 (final burst), or CALC in t+1.
- `valid` never drops while `pop_cnt` < `blen`. The write engine ignores `valid` outside its address phase.

## Configuration

- `DMA_W_4K_SPLIT_EN` defined: the burst length is additionally limited to (4096 − `cur_addr`[11:0])/B, so no burst crosses a 4 KB boundary.
- `DMA_W_4K_SPLIT_EN` undefined: bursts are limited only by `rem` and MAX_BURST.

## Test plan

- **Single burst**: `cfg_addr`=0x1000, `cfg_nbeats`=4, push 4 words, engine model pops them.
  - Required: one `valid` burst with `addr`=0x1000, `dma_len`=3, data popped in order, `done` pulses once.
- **Long transfer**: `cfg_nbeats`=600, `cfg_addr`=0.
  - Required: bursts at 0x0/len 255, 0x400/len 255, 0x800/len 87; total pops = 600.
- **4 KB split** (macro defined): `cfg_addr`=0xFF0, `cfg_nbeats`=16.
  - Required: bursts 0xFF0/len 3 and 0x1000/len 11.
  - Without the macro: a single burst 0xFF0/len 15.
- **Backpressure and empty**:
  - Keep the FIFO full with `ready` held 0 → `s_ready`=0.
  - Assert `ready` with an empty FIFO → `level` stays 0.
  - Push and pop in the same cycle → `level` unchanged.
- **Edge config**:
  - `cfg_nbeats`=0 → `done` at cycle 1, `valid` never asserted.
  - `cfg_start` while `busy` → ignored.
- **Reset mid-burst**: assert `rst_n`=0 during BURST.
  - Required: all outputs return to reset values asynchronously; a new transfer afterwards completes correctly.
